// File: rtl/spu_result_pipe.sv
// Result-delay and forwarding pipe after the MEM stage. Results enter stage 1 (ST3),
// shift one stage per cycle through to stage DEPTH (WB) and drive the register-file
// write port from there. Every in-flight entry is visible to three forwarding lookups.
module spu_result_pipe #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned DW    = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid_i,
    input  logic          in_reg_write_i,
    input  logic          in_mem_to_reg_i,
    input  logic [AW-1:0] in_rt_i,
    input  logic [2:0]    in_lat_i,
    input  logic [DW-1:0] in_alu_result_i,
    input  logic [DW-1:0] in_mem_rdata_i,
    input  logic [AW-1:0] q_ra_i,
    input  logic [AW-1:0] q_rb_i,
    input  logic [AW-1:0] q_rc_i,
    output logic          fwd_hit_ra_o,
    output logic          fwd_hit_rb_o,
    output logic          fwd_hit_rc_o,
    output logic [DW-1:0] fwd_data_ra_o,
    output logic [DW-1:0] fwd_data_rb_o,
    output logic [DW-1:0] fwd_data_rc_o,
    output logic          hazard_ra_o,
    output logic          hazard_rb_o,
    output logic          hazard_rc_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_rt_o,
    output logic [DW-1:0] wb_data_o,
    output logic [2:0]    inflight_o
);

    // Stage k = 1..DEPTH; stage 1 is the youngest entry, stage DEPTH is WB.
    logic          valid_q [1:DEPTH];
    logic          we_q    [1:DEPTH];
    logic [AW-1:0] rt_q    [1:DEPTH];
    logic [2:0]    lat_q   [1:DEPTH];
    logic [DW-1:0] data_q  [1:DEPTH];

    logic [2:0]    lat_d;
    logic [DW-1:0] data_d;

    // Entry capture: clamp latency into 1..DEPTH and pick the write-back source.
    always_comb begin
        lat_d = in_lat_i;
        if (in_lat_i == 3'd0) begin
            lat_d = 3'd1;
        end else if (32'(in_lat_i) > DEPTH) begin
            lat_d = 3'(DEPTH);
        end
        data_d = in_mem_to_reg_i ? in_mem_rdata_i : in_alu_result_i;
    end

    // Unconditional shift; no stall input, ID inserts bubbles instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                we_q[k]    <= 1'b0;
                rt_q[k]    <= '0;
                lat_q[k]   <= '0;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q[1] <= in_valid_i;
            we_q[1]    <= in_valid_i & in_reg_write_i;
            rt_q[1]    <= in_rt_i;
            lat_q[1]   <= lat_d;
            data_q[1]  <= data_d;
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                we_q[k]    <= we_q[k-1];
                rt_q[k]    <= rt_q[k-1];
                lat_q[k]   <= lat_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    logic [AW-1:0] q_addr  [3];
    logic          hit     [3];
    logic          hazard  [3];
    logic [DW-1:0] fdata   [3];
    logic          found;

    assign q_addr[0] = q_ra_i;
    assign q_addr[1] = q_rb_i;
    assign q_addr[2] = q_rc_i;

    // Forwarding lookup from registered state only; the youngest match decides,
    // so an older ready copy never hides a younger pending one.
    always_comb begin
        found = 1'b0;
        for (int p = 0; p < 3; p++) begin
            hit[p]    = 1'b0;
            hazard[p] = 1'b0;
            fdata[p]  = '0;
            found     = 1'b0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                if (!found && valid_q[k] && we_q[k] && (rt_q[k] == q_addr[p])) begin
                    found = 1'b1;
                    if (k >= 32'(lat_q[k])) begin
                        hit[p]   = 1'b1;
                        fdata[p] = data_q[k];
                    end else begin
                        hazard[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign fwd_hit_ra_o  = hit[0];
    assign fwd_hit_rb_o  = hit[1];
    assign fwd_hit_rc_o  = hit[2];
    assign fwd_data_ra_o = fdata[0];
    assign fwd_data_rb_o = fdata[1];
    assign fwd_data_rc_o = fdata[2];
    assign hazard_ra_o   = hazard[0];
    assign hazard_rb_o   = hazard[1];
    assign hazard_rc_o   = hazard[2];

    // Write port driven straight from the WB stage, zeroed when not writing.
    always_comb begin
        wb_we_o   = valid_q[DEPTH] & we_q[DEPTH];
        wb_rt_o   = wb_we_o ? rt_q[DEPTH] : '0;
        wb_data_o = wb_we_o ? data_q[DEPTH] : '0;
    end

    // Occupancy counts every valid entry, including non-writing ones.
    always_comb begin
        inflight_o = 3'd0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            inflight_o = inflight_o + 3'(valid_q[k]);
        end
    end

endmodule

// File: tb/tb_spu_result_pipe.sv
// Scoreboard bench for spu_result_pipe: writes are queued with their expected WB cycle
// and a negedge monitor retires them; forwarding and occupancy are checked directly.
module tb_spu_result_pipe;

    localparam int unsigned DEPTH = 6;
    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_reg_write, in_mem_to_reg;
    logic [AW-1:0] in_rt;
    logic [2:0]    in_lat;
    logic [DW-1:0] in_alu_result, in_mem_rdata;
    logic [AW-1:0] q_ra, q_rb, q_rc;
    logic          fwd_hit_ra, fwd_hit_rb, fwd_hit_rc;
    logic [DW-1:0] fwd_data_ra, fwd_data_rb, fwd_data_rc;
    logic          hazard_ra, hazard_rb, hazard_rc;
    logic          wb_we;
    logic [AW-1:0] wb_rt;
    logic [DW-1:0] wb_data;
    logic [2:0]    inflight;

    spu_result_pipe #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid_i      (in_valid),
        .in_reg_write_i  (in_reg_write),
        .in_mem_to_reg_i (in_mem_to_reg),
        .in_rt_i         (in_rt),
        .in_lat_i        (in_lat),
        .in_alu_result_i (in_alu_result),
        .in_mem_rdata_i  (in_mem_rdata),
        .q_ra_i          (q_ra),
        .q_rb_i          (q_rb),
        .q_rc_i          (q_rc),
        .fwd_hit_ra_o    (fwd_hit_ra),
        .fwd_hit_rb_o    (fwd_hit_rb),
        .fwd_hit_rc_o    (fwd_hit_rc),
        .fwd_data_ra_o   (fwd_data_ra),
        .fwd_data_rb_o   (fwd_data_rb),
        .fwd_data_rc_o   (fwd_data_rc),
        .hazard_ra_o     (hazard_ra),
        .hazard_rb_o     (hazard_rb),
        .hazard_rc_o     (hazard_rc),
        .wb_we_o         (wb_we),
        .wb_rt_o         (wb_rt),
        .wb_data_o       (wb_data),
        .inflight_o      (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rt;
        logic [DW-1:0] data;
        int unsigned   cyc;
    } wb_exp_t;

    wb_exp_t     sb [$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_lk(input string nm, input int p, input logic eh,
                          input logic [DW-1:0] ed, input logic ez);
        logic          h, z;
        logic [DW-1:0] d;
        case (p)
            0:       begin h = fwd_hit_ra; d = fwd_data_ra; z = hazard_ra; end
            1:       begin h = fwd_hit_rb; d = fwd_data_rb; z = hazard_rb; end
            default: begin h = fwd_hit_rc; d = fwd_data_rc; z = hazard_rc; end
        endcase
        chk({nm, "_hit"}, DW'(h), DW'(eh));
        chk({nm, "_data"}, d, ed);
        chk({nm, "_hazard"}, DW'(z), DW'(ez));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one result for the next edge; writing results go to the scoreboard.
    task automatic issue(input logic v, input logic rw, input logic m2r, input logic [AW-1:0] rt,
                         input logic [2:0] lat, input logic [DW-1:0] alu,
                         input logic [DW-1:0] mem, input logic [DW-1:0] exp_data);
        wb_exp_t e;
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_rt         = rt;
        in_lat        = lat;
        in_alu_result = alu;
        in_mem_rdata  = mem;
        if (v && rw && !reset) begin
            e.rt   = rt;
            e.data = exp_data;
            e.cyc  = cyc + DEPTH;
            sb.push_back(e);
        end
    endtask

    task automatic bubble();
        issue(1'b0, 1'b0, 1'b0, '0, 3'd0, '0, '0, '0);
    endtask

    // WB monitor: each write must match the oldest queued result in the expected cycle.
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected_we", DW'(wb_we), DW'(1'b0));
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_rt", DW'(wb_rt), DW'(e.rt));
                chk("wb_data", wb_data, e.data);
                chk("wb_cycle", DW'(cyc), DW'(e.cyc));
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            wb_exp_t e;
            e = sb.pop_front();
            chk("wb_missing_we", DW'(wb_we), DW'(1'b1));
        end
    end

    localparam logic [DW-1:0] A5 = {16{8'hA5}};

    initial begin
        reset = 1'b1;
        q_ra  = '0;
        q_rb  = '0;
        q_rc  = '0;
        bubble();
        tick();
        tick();
        chk("rst_wb_we", DW'(wb_we), '0);
        chk("rst_wb_rt", DW'(wb_rt), '0);
        chk("rst_wb_data", wb_data, '0);
        chk("rst_inflight", DW'(inflight), '0);
        for (int p = 0; p < 3; p++) chk_lk("rst_lk", p, 1'b0, '0, 1'b0);
        reset = 1'b0;

        // Single lat=1 write: forwardable at once, reaches WB after DEPTH-1 more edges.
        q_ra = 7'd5;
        issue(1'b1, 1'b1, 1'b0, 7'd5, 3'd1, A5, '0, A5);
        tick();
        bubble();
        for (int k = 1; k <= 6; k++) begin
            chk("t1_inflight", DW'(inflight), DW'(3'd1));
            chk_lk("t1_ra", 0, 1'b1, A5, 1'b0);
            tick();
        end
        chk("t1_inflight_empty", DW'(inflight), '0);
        chk_lk("t1_ra_gone", 0, 1'b0, '0, 1'b0);

        // lat=3: hazard at k=1,2, bypass from k=3 through WB.
        issue(1'b1, 1'b1, 1'b0, 7'd5, 3'd3, A5, '0, A5);
        tick();
        bubble();
        for (int k = 1; k <= 6; k++) begin
            if (k < 3) chk_lk("t2_ra_pending", 0, 1'b0, '0, 1'b1);
            else       chk_lk("t2_ra_ready", 0, 1'b1, A5, 1'b0);
            tick();
        end
        chk_lk("t2_ra_gone", 0, 1'b0, '0, 1'b0);

        // Memory-sourced result.
        q_rb = 7'd3;
        issue(1'b1, 1'b1, 1'b1, 7'd3, 3'd1, 128'hFFFF, 128'h1234, 128'h1234);
        tick();
        bubble();
        chk_lk("t3_rb_mem", 1, 1'b1, 128'h1234, 1'b0);
        repeat (6) tick();

        // Same rt back to back: younger pending entry hides the older ready one.
        q_ra = 7'd9;
        q_rb = 7'd9;
        q_rc = 7'd9;
        issue(1'b1, 1'b1, 1'b0, 7'd9, 3'd1, 128'h11, '0, 128'h11);
        tick();
        chk_lk("t4_rb_old", 1, 1'b1, 128'h11, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 7'd9, 3'd4, 128'h22, '0, 128'h22);
        tick();
        bubble();
        for (int k = 1; k <= 5; k++) begin
            if (k < 4) begin
                chk_lk("t4_rb_young_pending", 1, 1'b0, '0, 1'b1);
                chk_lk("t4_ra_same", 0, 1'b0, '0, 1'b1);
                chk_lk("t4_rc_same", 2, 1'b0, '0, 1'b1);
            end else begin
                chk_lk("t4_rb_young_ready", 1, 1'b1, 128'h22, 1'b0);
            end
            tick();
        end
        repeat (2) tick();

        // Latency clamping: 7 behaves as DEPTH, 0 behaves as 1.
        q_rc = 7'd12;
        issue(1'b1, 1'b1, 1'b0, 7'd12, 3'd7, 128'hC, '0, 128'hC);
        tick();
        bubble();
        for (int k = 1; k <= 6; k++) begin
            if (k < 6) chk_lk("t5_rc_clamp_pending", 2, 1'b0, '0, 1'b1);
            else       chk_lk("t5_rc_clamp_ready", 2, 1'b1, 128'hC, 1'b0);
            tick();
        end
        q_ra = 7'd13;
        issue(1'b1, 1'b1, 1'b0, 7'd13, 3'd0, 128'hD, '0, 128'hD);
        tick();
        bubble();
        chk_lk("t5_ra_lat0", 0, 1'b1, 128'hD, 1'b0);
        repeat (6) tick();

        // Non-writing valid entries fill the pipe: counted, never forwarded or written.
        q_rc = 7'd7;
        for (int i = 1; i <= 6; i++) begin
            issue(1'b1, 1'b0, 1'b0, 7'd7, 3'd1, DW'(i), '0, '0);
            tick();
            chk("t6_inflight_fill", DW'(inflight), DW'(i));
            chk_lk("t6_rc_nowrite", 2, 1'b0, '0, 1'b0);
        end
        bubble();
        for (int i = 5; i >= 0; i--) begin
            tick();
            chk("t6_inflight_drain", DW'(inflight), DW'(i));
        end

        // Reset with three writes in flight and a write presented on the reset edge.
        issue(1'b1, 1'b1, 1'b0, 7'd20, 3'd1, 128'h20, '0, 128'h20);
        tick();
        issue(1'b1, 1'b1, 1'b0, 7'd21, 3'd1, 128'h21, '0, 128'h21);
        tick();
        issue(1'b1, 1'b1, 1'b0, 7'd22, 3'd1, 128'h22, '0, 128'h22);
        tick();
        chk("t7_inflight_pre", DW'(inflight), DW'(3'd3));
        reset = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 7'd23, 3'd1, 128'h23, '0, 128'h23);
        sb.delete();
        tick();
        reset = 1'b0;
        bubble();
        q_ra = 7'd20;
        q_rb = 7'd21;
        q_rc = 7'd22;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) q_ra = 7'd23;
            chk("t7_inflight", DW'(inflight), '0);
            chk("t7_wb_we", DW'(wb_we), '0);
            for (int p = 0; p < 3; p++) chk_lk("t7_lk", p, 1'b0, '0, 1'b0);
            tick();
        end

        chk("sb_empty", DW'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
